// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM states and counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, b_in, input busy, done, diff, b_out, ovf);
  modport slave  (input start, a, b, b_in, output busy, done, diff, b_out, ovf);
`else
  modport master (output start, a, b, b_in, input busy, done, diff, b_out);
  modport slave  (input start, a, b, b_in, output busy, done, diff, b_out);
`endif
endinterface

// File: rtl/serial_subtractor_fullsub.sv
// Combinational 1-bit full subtractor: d = a - b - br_in with borrow out.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b - b_in, LSB first, start/busy/done handshake.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             b_out_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             br_next_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  fullsub u_fullsub (
    .a      (a_sh_r[0]),
    .b      (b_sh_r[0]),
    .br_in  (br_r),
    .d      (d_s),
    .br_out (br_next_s)
  );

  // Next-state decode; DONE accepts a new start just like IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          last_s       = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand shifting, borrow chain and result capture on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      diff_r  <= '0;
      cnt_r   <= '0;
      br_r    <= 1'b0;
      b_out_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      a_sh_r <= bus.a;
      b_sh_r <= bus.b;
      br_r   <= bus.b_in;
      res_r  <= '0;
      cnt_r  <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= bus.b[WIDTH-1];
`endif
    end else if (state_r == RUN) begin
      a_sh_r <= a_sh_r >> 1;
      b_sh_r <= b_sh_r >> 1;
      br_r   <= br_next_s;
      res_r  <= {d_s, res_r[WIDTH-1:1]};
      cnt_r  <= cnt_r + CW'(1);
      if (last_s) begin
        diff_r  <= {d_s, res_r[WIDTH-1:1]};
        b_out_r <= br_next_s;
`ifdef SERIAL_SUB_OVF_EN
        // The final d is the result MSB.
        ovf_r   <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
`endif
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.diff  = diff_r;
  assign bus.b_out = b_out_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor with WIDTH=8.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   cyc;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Start one operation; returns at the negedge right after the accept edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts cycles since the accept edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.b_in  = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.diff !== 8'h00) $display("FAIL reset_diff got %h want 00", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b0) $display("FAIL reset_b_out got %b want 0", bus.b_out); else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else pass_cnt++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int busy_n;
    launch(8'h50, 8'h20, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else pass_cnt++;
    total_cnt++; if (busy_n !== 8) $display("FAIL basic_busy_cycles got %0d want 8", busy_n); else pass_cnt++;
    total_cnt++; if (bus.diff !== 8'h30) $display("FAIL basic_diff got %h want 30", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b0) $display("FAIL basic_b_out got %b want 0", bus.b_out); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_with_done got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_borrow();
    int lat;
    int busy_n;
    launch(8'h00, 8'h01, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'hFF) $display("FAIL borrow0_diff got %h want ff", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b1) $display("FAIL borrow0_b_out got %b want 1", bus.b_out); else pass_cnt++;
    launch(8'h10, 8'h10, 1'b1);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'hFF) $display("FAIL borrow_in_diff got %h want ff", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b1) $display("FAIL borrow_in_b_out got %b want 1", bus.b_out); else pass_cnt++;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    int busy_n;
    launch(8'h80, 8'h01, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'h7F) $display("FAIL ovf1_diff got %h want 7f", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf1_ovf got %b want 1", bus.ovf); else pass_cnt++;
    launch(8'h7F, 8'hFF, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'h80) $display("FAIL ovf2_diff got %h want 80", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf2_ovf got %b want 1", bus.ovf); else pass_cnt++;
    launch(8'h05, 8'h03, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'h02) $display("FAIL ovf3_diff got %h want 02", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovf3_ovf got %b want 0", bus.ovf); else pass_cnt++;
  endtask
`endif

  task automatic test_start_during_run();
    int lat;
    int busy_n;
    int extra;
    launch(8'h50, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    bus.a     = 8'hAA;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    lat = lat + 3;
    total_cnt++; if (lat !== 8) $display("FAIL ignore_latency got %0d want 8", lat); else pass_cnt++;
    total_cnt++; if (bus.diff !== 8'h30) $display("FAIL ignore_diff got %h want 30", bus.diff); else pass_cnt++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL ignore_extra_done got %0d want 0", extra); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] op_a   [3];
    logic [7:0] op_b   [3];
    logic       op_bin [3];
    logic [7:0] exp_d  [3];
    logic       exp_bo [3];
    logic [7:0] prev;
    logic       stable;
    int         lat;
    int         last_cyc;
    op_a[0] = 8'hA7; op_b[0] = 8'h5B; op_bin[0] = 1'b0; exp_d[0] = 8'h4C; exp_bo[0] = 1'b0;
    op_a[1] = 8'h9C; op_b[1] = 8'h35; op_bin[1] = 1'b1; exp_d[1] = 8'h66; exp_bo[1] = 1'b0;
    op_a[2] = 8'h12; op_b[2] = 8'h34; op_bin[2] = 1'b0; exp_d[2] = 8'hDE; exp_bo[2] = 1'b1;
    prev     = 8'h30;
    last_cyc = 0;
    @(negedge clk);
    bus.a     = op_a[0];
    bus.b     = op_b[0];
    bus.b_in  = op_bin[0];
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        bus.a    = op_a[i+1];
        bus.b    = op_b[i+1];
        bus.b_in = op_bin[i+1];
      end else begin
        bus.start = 1'b0;
      end
      stable = 1'b1;
      lat    = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
        if (bus.diff !== prev) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
      total_cnt++; if (lat !== 8) $display("FAIL b2b%0d_latency got %0d want 8", i, lat); else pass_cnt++;
      total_cnt++; if (bus.diff !== exp_d[i]) $display("FAIL b2b%0d_diff got %h want %h", i, bus.diff, exp_d[i]); else pass_cnt++;
      total_cnt++; if (bus.b_out !== exp_bo[i]) $display("FAIL b2b%0d_b_out got %b want %b", i, bus.b_out, exp_bo[i]); else pass_cnt++;
      total_cnt++; if (stable !== 1'b1) $display("FAIL b2b%0d_diff_stable got %b want 1", i, stable); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (cyc - last_cyc !== 9) $display("FAIL b2b%0d_period got %0d want 9", i, cyc - last_cyc); else pass_cnt++;
      end
      last_cyc = cyc;
      prev     = exp_d[i];
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int busy_n;
    int extra;
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.diff !== 8'h00) $display("FAIL abort_diff got %h want 00", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b0) $display("FAIL abort_b_out got %b want 0", bus.b_out); else pass_cnt++;
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL abort_no_done got %0d want 0", extra); else pass_cnt++;
    launch(8'hF0, 8'h0F, 1'b0);
    wait_done(lat, busy_n);
    total_cnt++; if (bus.diff !== 8'hE1) $display("FAIL after_abort_diff got %h want e1", bus.diff); else pass_cnt++;
    total_cnt++; if (bus.b_out !== 1'b0) $display("FAIL after_abort_b_out got %b want 0", bus.b_out); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    test_reset();
    test_basic();
    test_borrow();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - b_in` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse arithmetic companion to the team's parallel full-adder datapath. It is used where area matters more than latency: one full-subtractor cell plus shift registers replaces a WIDTH-wide borrow chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; sampled on the accept edge.
- `b`  in  WIDTH  subtrahend; sampled on the accept edge.
- `b_in`  in  1  borrow in; sampled on the accept edge.
- `busy`  out  1  high while bits are being processed (RUN state).
- `done`  out  1  one-cycle pulse when `diff`/`b_out` become valid.
- `diff`  out  WIDTH  registered result; holds until the next completion.
- `b_out`  out  1  registered borrow out of the MSB.
- `ovf`  out  1  signed overflow flag; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1: latch `a`, `b`, `b_in` into shift/borrow registers; clear bit counter; go to RUN.
  - RUN: each edge processes the current LSB of the operand shift registers.
    - d = a_i ^ b_i ^ br.
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - Shift d into the result shift register from the MSB side; increment the counter.
    - After the WIDTH-th bit, go to DONE.
  - On entry to DONE: copy the result shift register to `diff` and the final br to `b_out`; `done`=1 for that cycle.
  - DONE: if `start`=1, accept the new operation exactly as IDLE does (back-to-back); otherwise go to IDLE.
- `start` while in RUN is ignored: no latch, no error, and the operation in flight is unaffected.
- `diff`, `b_out` and `ovf` change only on the entry-to-DONE edge. They stay stable during a following RUN.
- Arithmetic is modulo 2^WIDTH; `b_out`=1 exactly when a < b + b_in, taken as unsigned values.
- Reset values, all synchronous with `rst_n`=0 at an edge: state IDLE, `busy`=0, `done`=0, `diff`=0, `b_out`=0, `ovf`=0, counter 0.
- Reset mid-RUN aborts the operation. No `done` is produced, and outputs go to their reset values.

## Timing
- Accept edge T is the edge where `start`=1 and the state is IDLE or DONE.
- `busy`=1 from after edge T until edge T+WIDTH.
- Bits 0..WIDTH-1 are processed on edges T+1..T+WIDTH.
- `done`=1 and the new `diff`/`b_out` are visible in the cycle following edge T+WIDTH. Latency is WIDTH cycles.
- Throughput is one result per WIDTH+1 cycles with `start` held high. The DONE cycle doubles as the accept cycle, so there are no idle gaps.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Adds the `ovf` port: ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]).
  - Uses the latched operand MSBs.
  - Registered with `diff` and reset to 0.
- `SERIAL_SUB_OVF_EN` undefined: no `ovf` port, and no MSB capture logic.

## Structure
- Package `serial_sub_pkg`: FSM state enum (IDLE, RUN, DONE); counter width constant $clog2(WIDTH+1).
- Sub-module `fullsub`: combinational 1-bit full subtractor.
  - Inputs: a, b, br_in.
  - Outputs: d, br_out.
  - Instantiated once in the serial datapath.

## Test plan
All scenarios use WIDTH=8.
1. a=0x50, b=0x20, b_in=0 → `diff`=0x30, `b_out`=0; `done` exactly 8 cycles after the accept edge; `busy` high for 8 cycles.
2. a=0x00, b=0x01, b_in=0 → `diff`=0xFF, `b_out`=1; and a=0x10, b=0x10, b_in=1 → `diff`=0xFF, `b_out`=1.
3. With `SERIAL_SUB_OVF_EN`:
   - a=0x80, b=0x01 → `diff`=0x7F, `ovf`=1.
   - a=0x7F, b=0xFF → `diff`=0x80, `ovf`=1.
   - a=0x05, b=0x03 → `diff`=0x02, `ovf`=0.
4. Pulse `start` with a=0xAA during RUN of 0x50-0x20 → result is still 0x30, and no second `done` appears.
5. Hold `start` high across three operations → `done` pulses every 9 cycles, with correct `diff` each time; `diff` stays stable during each RUN.
6. Assert `rst_n`=0 at bit 4 of 0xF0-0x0F → all outputs 0 and no `done`. A following 0xF0-0x0F then yields 0xE1, `b_out`=0.
